// File: rtl/aes_state_demux_if.sv
// Bundle of block-control, feedback and ciphertext handshake signals around aes_state_demux.
// The master drives the round results and the downstream ready; the slave is the demux itself.
interface aes_state_demux_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 4
) ();
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              fb_valid;
    logic [DATA_W-1:0] fb_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  round_idx;
    logic              busy;
    logic              ovf;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  fb_valid, fb_data, out_valid, out_data, round_idx, busy, ovf
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output fb_valid, fb_data, out_valid, out_data, round_idx, busy, ovf
    );
endinterface

// File: rtl/aes_state_demux.sv
// Routes AES round results: rounds 1..NUM_ROUNDS-1 to the feedback mux, the last one to a
// valid/ready output holding register. Optional sticky overflow flag: AES_DEMUX_OVF_EN.
module aes_state_demux #(
    parameter int DATA_W     = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_state_demux_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  round_q, round_d;
    logic              fb_valid_q, fb_valid_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        round_d     = round_q;
        fb_valid_d  = 1'b0;
        fb_data_d   = fb_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    round_d = ONE;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    if (round_q < LAST_ROUND) begin
                        fb_data_d  = bus.in_data;
                        fb_valid_d = 1'b1;
                        round_d    = round_q + ONE;
                    end else begin
                        out_data_d  = bus.in_data;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                // A start arriving with the accepting ready chains straight into the next block.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.start) begin
                        state_d = RUN;
                        round_d = ONE;
                    end else begin
                        state_d = IDLE;
                        round_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_q     <= '0;
            fb_valid_q  <= 1'b0;
            fb_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            fb_valid_q  <= fb_valid_d;
            fb_data_q   <= fb_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef AES_DEMUX_OVF_EN
    logic ovf_q, ovf_d;

    // A beat arriving while the ciphertext is still held is lost; remember that it happened.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == HOLD && bus.in_valid) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.fb_valid  = fb_valid_q;
    assign bus.fb_data   = fb_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.round_idx = round_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
